// File: rtl/fp_pkg.sv
// Shared FPU types: formats, rounding modes, the unrounded result bundle and flag layout.
package fp_pkg;

    localparam int unsigned FLEN       = 64;
    localparam int unsigned GUARD_BITS = 2;

    typedef enum logic [1:0] {
        FP32    = 2'd0,
        FP64    = 2'd1,
        FP16    = 2'd2,
        FP16ALT = 2'd3
    } fp_format_e;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        DYN = 3'b111
    } roundmode_e;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } fp_encoding_t;

    // u_result is FLEN wide so one bundle type serves every format; narrow formats use the low bits.
    typedef struct packed {
        logic [FLEN-1:0]       u_result;
        logic [GUARD_BITS-1:0] rs;
        logic                  round_en;
        logic                  invalid;
        logic [1:0]            exp_cout;
    } uround_res_t;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    function automatic int unsigned exp_bits(fp_format_e fmt);
        case (fmt)
            FP64:    return 11;
            FP16:    return 5;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned man_bits(fp_format_e fmt);
        case (fmt)
            FP64:    return 52;
            FP16:    return 10;
            FP16ALT: return 7;
            default: return 23;
        endcase
    endfunction

    function automatic int unsigned fp_width(fp_format_e fmt);
        return 1 + exp_bits(fmt) + man_bits(fmt);
    endfunction

endpackage

// File: rtl/fp_round_inc.sv
// Rounding increment decision from mode, sign, lsb and the round/sticky bits.
module fp_round_inc
    import fp_pkg::*;
(
    input  roundmode_e mode,
    input  logic       sign,
    input  logic       lsb,
    input  logic       round_bit,
    input  logic       sticky_bit,
    output logic       inc
);

    // Unlisted encodings (including DYN) fall back to round-to-nearest-even.
    always_comb begin
        inc = 1'b0;
        case (mode)
            RTZ:     inc = 1'b0;
            RDN:     inc = sign & (round_bit | sticky_bit);
            RUP:     inc = ~sign & (round_bit | sticky_bit);
            RMM:     inc = round_bit;
            default: inc = round_bit & (sticky_bit | lsb);
        endcase
    end

endmodule

// File: rtl/fp_round_stage.sv
// Two-stage valid/ready rounding and packing stage: increment decision, carry/overflow resolution, flags.
module fp_round_stage
    import fp_pkg::*;
#(
    parameter fp_format_e FP_FORMAT = FP32,
    localparam int unsigned FP_WIDTH   = fp_width(FP_FORMAT),
    localparam int unsigned EXP_WIDTH  = exp_bits(FP_FORMAT),
    localparam int unsigned MANT_WIDTH = man_bits(FP_FORMAT)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  uround_res_t         urnd_i,
    input  roundmode_e          rnd_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [FP_WIDTH-1:0] result_o,
    output logic [4:0]          fflags_o
);

    localparam int unsigned EM_WIDTH = EXP_WIDTH + MANT_WIDTH;

    logic                s1_valid;
    logic                s2_valid;
    logic                s1_adv;
    logic                s2_adv;
    logic                s1_load;

    logic [FP_WIDTH-1:0] s1_res;
    logic                s1_inc;
    logic                s1_round_en;
    logic                s1_invalid;
    logic                s1_ovf_in;
    logic                s1_inexact;
    roundmode_e          s1_mode;

    logic                inc_d;
    logic [FP_WIDTH-1:0] result_q;
    fflags_t             fflags_q;

    logic [EM_WIDTH-1:0] sum;
    logic                s2_sign;
    logic                ovf;
    logic                to_inf;
    logic [FP_WIDTH-1:0] rnd_result;
    fflags_t             rnd_flags;

    assign s2_adv     = ~s2_valid | out_ready_i;
    assign s1_adv     = ~s1_valid | s2_adv;
    assign in_ready_o = s1_adv;
    assign s1_load    = in_valid_i & s1_adv & ~flush_i & ~reset_i;

    assign out_valid_o = s2_valid;
    assign result_o    = result_q;
    assign fflags_o    = fflags_q;

    fp_round_inc u_round_inc (
        .mode       (rnd_i),
        .sign       (urnd_i.u_result[FP_WIDTH-1]),
        .lsb        (urnd_i.u_result[0]),
        .round_bit  (urnd_i.rs[1]),
        .sticky_bit (urnd_i.rs[0]),
        .inc        (inc_d)
    );

    // Bits of the shared bundle that this format never looks at.
    if (FP_WIDTH < FLEN) begin : g_upper
        logic unused_upper;
        assign unused_upper = ^urnd_i.u_result[FLEN-1:FP_WIDTH];
    end
    logic unused_cout;
    assign unused_cout = urnd_i.exp_cout[0];

    always_ff @(posedge clk_i) begin
        if (s1_load) begin
            s1_res      <= urnd_i.u_result[FP_WIDTH-1:0];
            s1_inc      <= inc_d;
            s1_round_en <= urnd_i.round_en;
            s1_invalid  <= urnd_i.invalid;
            s1_ovf_in   <= urnd_i.exp_cout[1];
            s1_inexact  <= |urnd_i.rs;
            s1_mode     <= rnd_i;
        end
    end

    // Mantissa carry ripples into the exponent, so subnormal promotion needs no special case.
    always_comb begin
        s2_sign    = s1_res[FP_WIDTH-1];
        sum        = s1_res[EM_WIDTH-1:0] + {{(EM_WIDTH-1){1'b0}}, s1_inc};
        ovf        = (&sum[EM_WIDTH-1:MANT_WIDTH]) | s1_ovf_in;
        to_inf     = 1'b1;
        rnd_result = '0;
        rnd_flags  = '0;
        case (s1_mode)
            RTZ:     to_inf = 1'b0;
            RDN:     to_inf = s2_sign;
            RUP:     to_inf = ~s2_sign;
            default: to_inf = 1'b1;
        endcase
        if (!s1_round_en) begin
            rnd_result   = s1_res;
            rnd_flags.nv = s1_invalid;
        end else begin
            if (ovf && to_inf) begin
                rnd_result = {s2_sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
            end else if (ovf) begin
                rnd_result = {s2_sign, {(EXP_WIDTH-1){1'b1}}, 1'b0, {MANT_WIDTH{1'b1}}};
            end else begin
                rnd_result = {s2_sign, sum};
            end
            rnd_flags.nv = s1_invalid;
            rnd_flags.of = ovf;
            rnd_flags.nx = s1_inexact | ovf;
            rnd_flags.uf = (s1_inexact | ovf) & ~(|rnd_result[FP_WIDTH-2:MANT_WIDTH]);
        end
    end

    // Flush only drops valids; the data registers keep their last contents.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            result_q <= '0;
            fflags_q <= '0;
        end else if (flush_i) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid_i;
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
            end
            if (s2_adv && s1_valid) begin
                result_q <= rnd_result;
                fflags_q <= rnd_flags;
            end
        end
    end

endmodule

// File: tb/tb_fp_round_stage.sv
// Self-checking bench for fp_round_stage (FP32): directed vectors, backpressure, flush/reset, random stream.
module tb_fp_round_stage;
    import fp_pkg::*;

    logic        clk_i;
    logic        reset_i;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    uround_res_t urnd_i;
    roundmode_e  rnd_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] result_o;
    logic [4:0]  fflags_o;

    int checks;
    int failures;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  fl;
    } exp_t;

    fp_round_stage #(.FP_FORMAT(FP32)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .urnd_i      (urnd_i),
        .rnd_i       (rnd_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .fflags_o    (fflags_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: IEEE-754 FP32 rounding computed directly from the field values.
    function automatic exp_t model(input uround_res_t u, input roundmode_e m);
        exp_t        e;
        logic        sign;
        logic        r;
        logic        s;
        logic        inc;
        logic        inexact;
        logic        of;
        logic        inf;
        logic [31:0] mag;
        logic [31:0] sum;
        sign    = u.u_result[31];
        mag     = {1'b0, u.u_result[30:0]};
        r       = u.rs[1];
        s       = u.rs[0];
        inexact = r | s;
        if (!u.round_en) begin
            e.res = u.u_result[31:0];
            e.fl  = {u.invalid, 4'b0000};
            return e;
        end
        case (m)
            RTZ:     inc = 1'b0;
            RDN:     inc = sign && inexact;
            RUP:     inc = !sign && inexact;
            RMM:     inc = r;
            default: inc = r && (s || mag[0]);
        endcase
        sum = (mag + {31'd0, inc}) & 32'h7FFF_FFFF;
        of  = (sum[30:23] == 8'hFF) || u.exp_cout[1];
        if (of) begin
            if (m == RTZ)      inf = 1'b0;
            else if (m == RDN) inf = sign;
            else if (m == RUP) inf = !sign;
            else               inf = 1'b1;
            sum = inf ? 32'h7F80_0000 : 32'h7F7F_FFFF;
        end
        e.res = {sign, sum[30:0]};
        e.fl  = {u.invalid, 1'b0, of, (inexact || of) && (sum[30:23] == 8'h00), inexact || of};
        return e;
    endfunction

    function automatic uround_res_t rand_bundle();
        uround_res_t u;
        int unsigned k;
        k = $urandom_range(0, 4);
        u = '0;
        u.u_result[31:0] = $urandom;
        if (k == 0) u.u_result[30:23] = 8'hFE;
        if (k == 1) u.u_result[30:23] = 8'h00;
        if (k == 2) u.u_result[22:0]  = 23'h7F_FFFF;
        u.rs          = 2'($urandom_range(0, 3));
        u.round_en    = ($urandom_range(0, 7) != 0);
        u.invalid     = ($urandom_range(0, 7) == 0);
        u.exp_cout[1] = ($urandom_range(0, 9) == 0);
        u.exp_cout[0] = 1'($urandom_range(0, 1));
        return u;
    endfunction

    function automatic uround_res_t mk(input logic [31:0] v, input logic [1:0] rs,
                                       input logic en, input logic inv, input logic cout);
        uround_res_t u;
        u                 = '0;
        u.u_result[31:0]  = v;
        u.rs              = rs;
        u.round_en        = en;
        u.invalid         = inv;
        u.exp_cout[1]     = cout;
        return u;
    endfunction

    task automatic test_reset();
        reset_i     = 1'b1;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        urnd_i      = '0;
        rnd_i       = RNE;
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        checks++;
        if (out_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid_o); end
        checks++;
        if (result_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_result got=%h exp=00000000", result_o); end
        checks++;
        if (fflags_o !== 5'b0) begin failures++; $display("[TB] FAIL reset_fflags got=%b exp=00000", fflags_o); end
        checks++;
        if (in_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready_o); end
    endtask

    task automatic test_directed();
        uround_res_t vec_u [10];
        roundmode_e  vec_m [10];
        logic [31:0] vec_r [10];
        logic [4:0]  vec_f [10];
        vec_u[0] = mk(32'h3F80_0000, 2'b11, 1, 0, 0); vec_m[0] = RNE; vec_r[0] = 32'h3F80_0001; vec_f[0] = 5'b00001;
        vec_u[1] = mk(32'h3F80_0000, 2'b10, 1, 0, 0); vec_m[1] = RNE; vec_r[1] = 32'h3F80_0000; vec_f[1] = 5'b00001;
        vec_u[2] = mk(32'h3F80_0001, 2'b10, 1, 0, 0); vec_m[2] = RNE; vec_r[2] = 32'h3F80_0002; vec_f[2] = 5'b00001;
        vec_u[3] = mk(32'h7F7F_FFFF, 2'b11, 1, 0, 0); vec_m[3] = RNE; vec_r[3] = 32'h7F80_0000; vec_f[3] = 5'b00101;
        vec_u[4] = mk(32'h7F7F_FFFF, 2'b11, 1, 0, 0); vec_m[4] = RTZ; vec_r[4] = 32'h7F7F_FFFF; vec_f[4] = 5'b00001;
        vec_u[5] = mk(32'hFF7F_FFFF, 2'b11, 1, 0, 0); vec_m[5] = RDN; vec_r[5] = 32'hFF80_0000; vec_f[5] = 5'b00101;
        vec_u[6] = mk(32'h7FC0_0000, 2'b11, 0, 1, 0); vec_m[6] = RNE; vec_r[6] = 32'h7FC0_0000; vec_f[6] = 5'b10000;
        vec_u[7] = mk(32'h4200_0000, 2'b00, 1, 0, 1); vec_m[7] = RTZ; vec_r[7] = 32'h7F7F_FFFF; vec_f[7] = 5'b00101;
        vec_u[8] = mk(32'h0000_0001, 2'b01, 1, 0, 0); vec_m[8] = RTZ; vec_r[8] = 32'h0000_0001; vec_f[8] = 5'b00011;
        vec_u[9] = mk(32'h007F_FFFF, 2'b11, 1, 0, 0); vec_m[9] = RNE; vec_r[9] = 32'h0080_0000; vec_f[9] = 5'b00001;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            urnd_i      = vec_u[i];
            rnd_i       = vec_m[i];
            in_valid_i  = 1'b1;
            out_ready_i = 1'b1;
            #1;
            checks++;
            if (in_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL dir%0d_in_ready got=%b exp=1", i, in_ready_o); end
            @(negedge clk_i);
            in_valid_i = 1'b0;
            urnd_i     = rand_bundle();
            #1;
            checks++;
            if (out_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL dir%0d_early_valid got=%b exp=0", i, out_valid_o); end
            @(negedge clk_i);
            #1;
            checks++;
            if (out_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL dir%0d_latency got=%b exp=1", i, out_valid_o); end
            checks++;
            if (result_o !== vec_r[i]) begin failures++; $display("[TB] FAIL dir%0d_result got=%h exp=%h", i, result_o, vec_r[i]); end
            checks++;
            if (fflags_o !== vec_f[i]) begin failures++; $display("[TB] FAIL dir%0d_fflags got=%b exp=%b", i, fflags_o, vec_f[i]); end
        end
    endtask

    task automatic test_backpressure();
        uround_res_t items [3];
        roundmode_e  modes [3];
        exp_t        expv  [3];
        logic [31:0] held_res;
        logic [4:0]  held_fl;
        int          accepted;
        int          got;
        for (int i = 0; i < 3; i++) begin
            items[i]          = rand_bundle();
            items[i].round_en = 1'b1;
            modes[i]          = roundmode_e'(3'($urandom_range(0, 4)));
            expv[i]           = model(items[i], modes[i]);
        end
        accepted = 0;
        @(negedge clk_i);
        out_ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk_i);
            in_valid_i = (accepted < 3);
            urnd_i     = items[accepted < 3 ? accepted : 2];
            rnd_i      = modes[accepted < 3 ? accepted : 2];
            #1;
            if (c == 2) begin
                held_res = result_o;
                held_fl  = fflags_o;
            end
            if (c > 2) begin
                checks++;
                if (out_valid_o !== 1'b1 || result_o !== held_res || fflags_o !== held_fl) begin
                    failures++;
                    $display("[TB] FAIL bp_stable got=%b/%h/%b exp=1/%h/%b", out_valid_o, result_o, fflags_o, held_res, held_fl);
                end
            end
            if (in_valid_i && in_ready_o) accepted++;
        end
        checks++;
        if (accepted !== 2) begin failures++; $display("[TB] FAIL bp_accepts got=%0d exp=2", accepted); end
        checks++;
        if (in_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL bp_in_ready got=%b exp=0", in_ready_o); end
        got = 0;
        for (int c = 0; c < 15 && got < 3; c++) begin
            @(negedge clk_i);
            out_ready_i = 1'b1;
            in_valid_i  = (accepted < 3);
            urnd_i      = items[accepted < 3 ? accepted : 2];
            rnd_i       = modes[accepted < 3 ? accepted : 2];
            #1;
            if (out_valid_o) begin
                checks++;
                if (result_o !== expv[got].res || fflags_o !== expv[got].fl) begin
                    failures++;
                    $display("[TB] FAIL bp_order%0d got=%h/%b exp=%h/%b", got, result_o, fflags_o, expv[got].res, expv[got].fl);
                end
                got++;
            end
            if (in_valid_i && in_ready_o) accepted++;
        end
        checks++;
        if (got !== 3) begin failures++; $display("[TB] FAIL bp_count got=%0d exp=3", got); end
        @(negedge clk_i);
        in_valid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            #1;
            checks++;
            if (out_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL bp_duplicate got=%b exp=0", out_valid_o); end
        end
    endtask

    task automatic fill_two();
        @(negedge clk_i);
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        urnd_i      = rand_bundle();
        @(negedge clk_i);
        urnd_i      = rand_bundle();
        @(negedge clk_i);
        #1;
        checks++;
        if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL fill_two got=%b/%b exp=0/1", in_ready_o, out_valid_o);
        end
    endtask

    task automatic test_flush_reset();
        for (int pass = 0; pass < 2; pass++) begin
            fill_two();
            if (pass == 0) flush_i = 1'b1;
            else           reset_i = 1'b1;
            in_valid_i = 1'b1;
            urnd_i     = rand_bundle();
            @(negedge clk_i);
            flush_i     = 1'b0;
            reset_i     = 1'b0;
            in_valid_i  = 1'b0;
            out_ready_i = 1'b1;
            #1;
            checks++;
            if (out_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL clear%0d_valid got=%b exp=0", pass, out_valid_o); end
            if (pass == 1) begin
                checks++;
                if (result_o !== 32'h0) begin failures++; $display("[TB] FAIL reset2_result got=%h exp=00000000", result_o); end
                checks++;
                if (fflags_o !== 5'b0) begin failures++; $display("[TB] FAIL reset2_fflags got=%b exp=00000", fflags_o); end
                checks++;
                if (in_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL reset2_in_ready got=%b exp=1", in_ready_o); end
            end
            for (int c = 0; c < 4; c++) begin
                @(negedge clk_i);
                #1;
                checks++;
                if (out_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL clear%0d_stale got=%b exp=0", pass, out_valid_o); end
            end
        end
    endtask

    task automatic test_random_stream();
        exp_t        q[$];
        exp_t        e;
        logic        hold;
        logic        exp_ready;
        logic [31:0] held_res;
        logic [4:0]  held_fl;
        hold = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk_i);
            in_valid_i  = ($urandom_range(0, 3) != 0);
            urnd_i      = rand_bundle();
            rnd_i       = roundmode_e'(3'($urandom_range(0, 7)));
            out_ready_i = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready = !(q.size() == 2 && !out_ready_i);
            checks++;
            if (in_ready_o !== exp_ready) begin failures++; $display("[TB] FAIL rnd_in_ready cyc=%0d got=%b exp=%b", c, in_ready_o, exp_ready); end
            if (hold) begin
                checks++;
                if (out_valid_o !== 1'b1 || result_o !== held_res || fflags_o !== held_fl) begin
                    failures++;
                    $display("[TB] FAIL rnd_hold cyc=%0d got=%b/%h/%b exp=1/%h/%b", c, out_valid_o, result_o, fflags_o, held_res, held_fl);
                end
            end
            if (out_valid_o && out_ready_i) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL rnd_spurious cyc=%0d got=%h exp=none", c, result_o);
                end else begin
                    e = q.pop_front();
                    if (result_o !== e.res || fflags_o !== e.fl) begin
                        failures++;
                        $display("[TB] FAIL rnd_data cyc=%0d got=%h/%b exp=%h/%b", c, result_o, fflags_o, e.res, e.fl);
                    end
                end
            end
            hold     = out_valid_o && !out_ready_i;
            held_res = result_o;
            held_fl  = fflags_o;
            if (in_valid_i && in_ready_o) q.push_back(model(urnd_i, rnd_i));
        end
        for (int c = 0; c < 10 && q.size() > 0; c++) begin
            @(negedge clk_i);
            in_valid_i  = 1'b0;
            out_ready_i = 1'b1;
            #1;
            if (out_valid_o) begin
                e = q.pop_front();
                checks++;
                if (result_o !== e.res || fflags_o !== e.fl) begin
                    failures++;
                    $display("[TB] FAIL rnd_drain got=%h/%b exp=%h/%b", result_o, fflags_o, e.res, e.fl);
                end
            end
        end
        checks++;
        if (q.size() != 0) begin failures++; $display("[TB] FAIL rnd_lost got=%0d exp=0", q.size()); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_flush_reset();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
